// File: rtl/state_unpack_mask_share_if.sv
// Stream bundle between the coefficient unpacker, the mask RNG and the share-pair consumer.
// Master drives coefficients, RNG word, clear and downstream ready; slave returns shares and status.
interface state_unpack_mask_share_if #(
    parameter int COEFF_SZ = 16,
    parameter int IDX_W    = 8
);
    logic                clr;
    logic [COEFF_SZ-1:0] rand_in;
    logic [COEFF_SZ-1:0] in_coeff;
    logic                in_valid;
    logic                in_ready;
    logic [COEFF_SZ-1:0] out_share0;
    logic [COEFF_SZ-1:0] out_share1;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;
    logic [IDX_W-1:0]    out_idx;
    logic                err_range;

    modport master (
        output clr, rand_in, in_coeff, in_valid, out_ready,
        input  in_ready, out_share0, out_share1, out_valid, out_last, out_idx, err_range
    );

    modport slave (
        input  clr, rand_in, in_coeff, in_valid, out_ready,
        output in_ready, out_share0, out_share1, out_valid, out_last, out_idx, err_range
    );
endinterface

// File: rtl/state_unpack_mask_share.sv
// Splits each coefficient c into arithmetic shares mod 3329: share1 = r, share0 = (c - r) mod Q.
// Two register stages (accept -> out_valid two cycles later); a stalled output freezes both stages.
module state_unpack_mask_share #(
    parameter int COEFF_SZ = 16,
    parameter int N_COEFFS = 256,
    parameter int WARMUP   = 8,
    localparam int IDX_W   = $clog2(N_COEFFS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    state_unpack_mask_share_if.slave  bus
);
    localparam logic [11:0] Q12    = 12'd3329;
    localparam logic [12:0] Q13    = 13'd3329;
    localparam int          WCNT_W = $clog2(WARMUP + 1);

    logic [WCNT_W-1:0] warm_cnt;
    logic              warm;
    logic              adv;
    logic              accept;
    logic [11:0]       c_raw;
    logic              c_oor;
    logic [11:0]       c_red;

    logic              s1_valid;
    logic [11:0]       s1_c;
    logic [10:0]       s1_r;
    logic [12:0]       diff;
    logic [12:0]       sh0_next;

    logic              s2_valid;
    logic [11:0]       s2_sh0;
    logic [10:0]       s2_sh1;
    logic [IDX_W-1:0]  idx;
    logic              err;

    // Only the low 12 coefficient bits and low 11 RNG bits carry information.
    logic unused_bits;
    assign unused_bits = ^{bus.in_coeff[COEFF_SZ-1:12], bus.rand_in[COEFF_SZ-1:11]};

    // Warmup counter saturates at WARMUP; only rst_n restarts it, clr leaves it alone.
    assign warm = (warm_cnt == WCNT_W'(WARMUP));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            warm_cnt <= '0;
        else if (!warm)
            warm_cnt <= warm_cnt + 1'b1;
    end

    assign adv          = !s2_valid || bus.out_ready;
    assign bus.in_ready = warm && adv && !bus.clr;
    assign accept       = bus.in_valid && bus.in_ready;

    assign c_raw = bus.in_coeff[11:0];
    assign c_oor = (c_raw >= Q12);
    assign c_red = c_oor ? (c_raw - Q12) : c_raw;

    // Stage 1: reduced coefficient and the RNG word sampled on the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_c     <= '0;
            s1_r     <= '0;
        end else if (bus.clr) begin
            s1_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= accept;
            if (accept) begin
                s1_c <= c_red;
                s1_r <= bus.rand_in[10:0];
            end
        end
    end

    // A negative difference wraps in 13 bits; adding Q brings it back into [0, Q-1].
    assign diff     = {1'b0, s1_c} - {2'b00, s1_r};
    assign sh0_next = diff[12] ? (diff + Q13) : diff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sh0   <= '0;
            s2_sh1   <= '0;
        end else if (bus.clr) begin
            s2_valid <= 1'b0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sh0 <= sh0_next[11:0];
                s2_sh1 <= s1_r;
            end
        end
    end

    // clr wins over a coincident output handshake, so that transfer is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idx <= '0;
        else if (bus.clr)
            idx <= '0;
        else if (s2_valid && bus.out_ready)
            idx <= (idx == IDX_W'(N_COEFFS - 1)) ? '0 : idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err <= 1'b0;
        else if (accept && c_oor)
            err <= 1'b1;
    end

    assign bus.out_valid  = s2_valid;
    assign bus.out_share0 = {{(COEFF_SZ-12){1'b0}}, s2_sh0};
    assign bus.out_share1 = {{(COEFF_SZ-11){1'b0}}, s2_sh1};
    assign bus.out_idx    = idx;
    assign bus.out_last   = s2_valid && (idx == IDX_W'(N_COEFFS - 1));
    assign bus.err_range  = err;
endmodule

// File: tb/tb_state_unpack_mask_share.sv
// Randomized and directed bench for state_unpack_mask_share against a queue-based share model.
module tb_state_unpack_mask_share;
    localparam int WARMUP = 8;
    localparam int NC     = 256;
    localparam int Q      = 3329;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    state_unpack_mask_share_if #(.COEFF_SZ(16), .IDX_W(8)) bus ();

    state_unpack_mask_share #(.COEFF_SZ(16), .N_COEFFS(NC), .WARMUP(WARMUP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int s0;
        int s1;
        int cyc;
    } exp_t;

    exp_t mq[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   since_rst = 0;
    int   exp_idx = 0;
    bit   err_exp = 1'b0;
    int   n_in = 0;
    int   n_out = 0;
    int   n_last = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_share0(input int c, input int r);
        int cc;
        cc = c % 4096;
        if (cc >= Q) cc = cc - Q;
        return (cc - r + Q) % Q;
    endfunction

    task automatic set_in(input int c, input int r, input bit v, input bit ordy, input bit clr);
        bus.in_coeff  = 16'(c);
        bus.rand_in   = 16'(r);
        bus.in_valid  = v;
        bus.out_ready = ordy;
        bus.clr       = clr;
    endtask

    // One cycle: check visible state against the model, then apply this cycle's transfers.
    task automatic tick();
        bit   ov_exp, hs_in, hs_out, last_seen;
        int   c, r;
        exp_t e;
        #1;
        ov_exp = (mq.size() > 0) && (mq[0].cyc < cyc);
        check_eq("out_valid", bus.out_valid, ov_exp);
        check_eq("in_ready", bus.in_ready,
                 (since_rst >= WARMUP) && (!ov_exp || bus.out_ready) && !bus.clr);
        check_eq("err_range", bus.err_range, err_exp);
        check_eq("out_idx", bus.out_idx, exp_idx);
        check_eq("out_last", bus.out_last, ov_exp && (exp_idx == NC - 1));
        if (ov_exp) begin
            check_eq("share0", bus.out_share0, mq[0].s0);
            check_eq("share1", bus.out_share1, mq[0].s1);
        end
        hs_in     = bus.in_valid && bus.in_ready;
        hs_out    = bus.out_valid && bus.out_ready;
        last_seen = bus.out_last;
        c = int'(bus.in_coeff[11:0]);
        r = int'(bus.rand_in[10:0]);
        @(posedge clk);
        cyc++;
        since_rst++;
        if (bus.clr) begin
            mq.delete();
            exp_idx = 0;
        end else begin
            if (hs_out && mq.size() > 0) begin
                void'(mq.pop_front());
                exp_idx = (exp_idx + 1) % NC;
                n_out++;
                if (last_seen) n_last++;
            end
            if (hs_in) begin
                e.s0 = ref_share0(c, r);
                e.s1 = r;
                e.cyc = cyc;
                mq.push_back(e);
                n_in++;
                if (c >= Q) err_exp = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_out_idx", bus.out_idx, 0);
        check_eq("rst_in_ready", bus.in_ready, 0);
        check_eq("rst_err_range", bus.err_range, 0);
        check_eq("rst_share0", bus.out_share0, 0);
        check_eq("rst_share1", bus.out_share1, 0);
        mq.delete();
        exp_idx = 0;
        err_exp = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        since_rst = 0;
    endtask

    task automatic warm_up();
        for (int i = 0; i < WARMUP + 1; i++) begin
            set_in($urandom_range(0, Q - 1), $urandom_range(0, 2047), 1'b1, 1'b1, 1'b0);
            #1;
            check_eq("warmup_ready", bus.in_ready, (i == WARMUP));
            tick();
        end
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (mq.size() > 0 && k < budget) begin
            set_in(0, $urandom_range(0, 2047), 1'b0, 1'b1, 1'b0);
            tick();
            k++;
        end
        check_eq("drain_timeout", mq.size(), 0);
    endtask

    task automatic directed(input string tag, input int c, input int r, input int s0);
        set_in(c, r, 1'b1, 1'b1, 1'b0);
        tick();
        set_in(0, $urandom_range(0, 2047), 1'b0, 1'b1, 1'b0);
        tick();
        #1;
        check_eq({tag, "_valid"}, bus.out_valid, 1);
        check_eq({tag, "_share0"}, bus.out_share0, s0);
        check_eq({tag, "_share1"}, bus.out_share1, r);
        tick();
    endtask

    initial begin
        int k, start_out, start_last;
        set_in(0, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        do_reset();

        // Warmup: ready stays low for 8 cycles, rises on the 9th.
        warm_up();
        drain(10);

        directed("c100_r40", 100, 40, 60);
        directed("c10_r2000", 10, 2000, 1339);
        directed("c3500_r0", 3500, 0, 171);
        check_eq("err_sticky_set", bus.err_range, 1);
        directed("after_err", 5, 3, 2);
        check_eq("err_sticky_hold", bus.err_range, 1);

        // Full polynomial with out_ready toggling every cycle.
        set_in(0, 0, 1'b0, 1'b1, 1'b1);
        tick();
        start_out = n_out;
        start_last = n_last;
        k = 0;
        while ((n_out - start_out) < NC && k < 4 * NC) begin
            set_in($urandom_range(0, 4095), $urandom_range(0, 2047),
                   (n_in - start_out) < NC, k[0] == 1'b0, 1'b0);
            tick();
            k++;
        end
        check_eq("poly_pairs", n_out - start_out, NC);
        check_eq("poly_last_count", n_last - start_last, 1);
        #1;
        check_eq("poly_idx_wrap", bus.out_idx, 0);
        drain(10);

        // Reset with two pairs in flight.
        set_in(200, 100, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(300, 50, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(0, 0, 1'b0, 1'b0, 1'b0);
        do_reset();
        warm_up();

        // Clear during a stall empties the pipeline.
        set_in(400, 7, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(500, 9, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(600, 11, 1'b1, 1'b0, 1'b1);
        tick();
        set_in(0, 0, 1'b0, 1'b0, 1'b0);
        #1;
        check_eq("clr_out_valid", bus.out_valid, 0);
        check_eq("clr_in_ready", bus.in_ready, 1);
        check_eq("clr_idx", bus.out_idx, 0);
        tick();

        // Random traffic with occasional clears.
        for (int i = 0; i < 1500; i++) begin
            set_in($urandom_range(0, 4095), $urandom_range(0, 2047),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                   $urandom_range(0, 63) == 0);
            tick();
        end
        drain(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
